// File: rtl/tl_rr_burst_arbiter.sv
// tl_rr_burst_arbiter
//   Round-robin N:1 arbiter for TileLink-style multi-beat channels. The grant is
//   combinational (zero latency). A multi-beat burst freezes the grant on one
//   requester until its last beat fires. Priority then rotates to just past that
//   requester.
//   Optional feature macro: ARB_LOCK_WDOG_EN adds a sticky lock watchdog that
//   reports a locked requester that stays idle too long. The lock itself is
//   never broken by the watchdog.
module tl_rr_burst_arbiter #(
  parameter int N           = 4,
  parameter int W           = 64,
  parameter int BEAT_W      = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N-1:0]          io_in_valid,
  output logic [N-1:0]          io_in_ready,
  input  logic [N*W-1:0]        io_in_bits,
  input  logic [N*BEAT_W-1:0]   io_in_beats,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [W-1:0]          io_out_bits,
  output logic [$clog2(N)-1:0]  io_chosen,
  output logic                  io_locked,
  output logic                  io_lock_err
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, LOCKED} state_t;

  if (N < 2 || BEAT_W < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("tl_rr_burst_arbiter: need N>=2, BEAT_W>=1, WDOG_CYCLES>=1");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;        // last requester that finished a burst
  logic [IDX_W-1:0]   lg;         // requester holding the lock
  logic [BEAT_W-1:0]  cnt;        // beats still to come in the locked burst

  logic [W-1:0]       bits_arr  [N];
  logic [BEAT_W-1:0]  beats_arr [N];

  logic [IDX_W-1:0]   scan_idx;
  logic               scan_hit;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   grant_idx;
  logic               have_grant;
  logic               active;
  logic               fire;
  logic [BEAT_W-1:0]  grant_beats;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign bits_arr[i]  = io_in_bits[i*W +: W];
    assign beats_arr[i] = io_in_beats[i*BEAT_W +: BEAT_W];
  end

  // Round-robin scan: first valid requester starting just after ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    scan_idx = '0;
    scan_hit = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!scan_hit && io_in_valid[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // Grant selection: frozen on lg while locked, otherwise the scan winner.
  always_comb begin
    grant_idx  = scan_idx;
    have_grant = scan_hit;
    if (state == LOCKED) begin
      grant_idx  = lg;
      have_grant = 1'b1;
    end
  end

  assign grant_beats  = beats_arr[grant_idx];
  assign active       = reset_n & ((state == LOCKED) ? io_in_valid[lg] : scan_hit);
  assign fire         = active & io_out_ready;

  assign io_out_valid = active;
  assign io_chosen    = (reset_n && have_grant) ? grant_idx : '0;
  assign io_out_bits  = (reset_n && have_grant) ? bits_arr[grant_idx] : '0;
  assign io_in_ready  = (reset_n && have_grant && io_out_ready) ? (N'(1) << grant_idx) : '0;
  assign io_locked    = (state == LOCKED);

  // Burst FSM: start/finish bursts on fire, rotate ptr after each last beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= IDX_W'(N - 1);
      lg    <= '0;
      cnt   <= '0;
    end else if (fire) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (grant_beats == '0) begin
            ptr <= grant_idx;
          end else begin
            cnt   <= grant_beats;
            lg    <= grant_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          cnt <= cnt - 1'b1;
          if (cnt == BEAT_W'(1)) begin
            ptr   <= lg;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_LOCK_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

  logic [WD_W-1:0] wdog;
  logic            lock_err;

  // Lock watchdog: count idle cycles of the locked requester, flag at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog     <= '0;
      lock_err <= 1'b0;
    end else if (fire || state == IDLE) begin
      wdog <= '0;
    end else if (!io_in_valid[lg]) begin
      if (wdog == WD_W'(WDOG_CYCLES - 1)) begin
        lock_err <= 1'b1;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  assign io_lock_err = lock_err;
`else
  assign io_lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_rr_burst_arbiter.sv
// tb_tl_rr_burst_arbiter
//   Directed scenarios plus a randomized run against a burst-level reference
//   model (pointer, beats remaining, idle-cycle count). Builds with or without
//   ARB_LOCK_WDOG_EN.
module tb_tl_rr_burst_arbiter;

  localparam int N      = 4;
  localparam int W      = 16;
  localparam int BEAT_W = 4;
  localparam int WDOG   = 8;
  localparam int IDX_W  = 2;
`ifdef ARB_LOCK_WDOG_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [W-1:0]         bits_a  [N];
  logic [BEAT_W-1:0]    beats_a [N];
  logic [N*W-1:0]       in_bits;
  logic [N*BEAT_W-1:0]  in_beats;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_bits;
  logic [IDX_W-1:0]     chosen;
  logic                 locked;
  logic                 lock_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_ptr, m_left, m_lg, m_wd;
  bit m_err;
  // model expectations for the current cycle
  bit               e_ov, e_locked, e_err, e_fire;
  int               e_g;
  logic [IDX_W-1:0] e_chosen;
  logic [N-1:0]     e_ready;
  logic [W-1:0]     e_bits;

  always #5 clock = ~clock;

  always_comb begin
    in_bits  = '0;
    in_beats = '0;
    for (int i = 0; i < N; i++) begin
      in_bits[i*W +: W]           = bits_a[i];
      in_beats[i*BEAT_W +: BEAT_W] = beats_a[i];
    end
  end

  tl_rr_burst_arbiter #(.N(N), .W(W), .BEAT_W(BEAT_W), .WDOG_CYCLES(WDOG)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_bits   (in_bits),
    .io_in_beats  (in_beats),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_bits  (out_bits),
    .io_chosen    (chosen),
    .io_locked    (locked),
    .io_lock_err  (lock_err)
  );

  function automatic void model_reset();
    m_ptr  = N - 1;
    m_left = 0;
    m_lg   = 0;
    m_wd   = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_eval();
    bit any;
    int idx;
    any      = 1'b0;
    e_g      = 0;
    e_locked = (m_left > 0);
    e_err    = m_err;
    e_ov     = 1'b0;
    if (!reset_n) begin
      e_locked = 1'b0;
    end else if (e_locked) begin
      any  = 1'b1;
      e_g  = m_lg;
      e_ov = in_valid[m_lg];
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (!any && in_valid[idx]) begin
          any = 1'b1;
          e_g = idx;
        end
      end
      e_ov = any;
    end
    e_chosen = any ? e_g[IDX_W-1:0] : '0;
    e_bits   = any ? bits_a[e_g] : '0;
    e_ready  = (any && out_ready) ? (N'(1) << e_g) : '0;
    e_fire   = e_ov && out_ready;
  endfunction

  function automatic void model_step();
    bit was_locked;
    if (!reset_n) return;
    was_locked = (m_left > 0);
    if (e_fire) begin
      m_wd = 0;
      if (was_locked) begin
        m_left = m_left - 1;
        if (m_left == 0) m_ptr = m_lg;
      end else if (beats_a[e_g] == 0) begin
        m_ptr = e_g;
      end else begin
        m_left = int'(beats_a[e_g]);
        m_lg   = e_g;
      end
    end else if (was_locked && !in_valid[m_lg]) begin
      m_wd = m_wd + 1;
      if (m_wd >= WDOG && EXP_ERR) m_err = 1'b1;
    end else if (!was_locked) begin
      m_wd = 0;
    end
  endfunction

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic adv();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    model_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bits_a[i]  = W'(16'hA000 + i);
      beats_a[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // one single-beat fire from requester 0 so the pointer sits at 0
  task automatic prime();
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    settle();
    adv();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    model_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bits_a[i]  = W'(16'hA000 + i);
      beats_a[i] = '0;
    end
    @(posedge clock);
    #1;
    settle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (chosen !== 2'd0 || out_bits !== '0) begin n_fail++; $display("FAIL reset_chosen_bits: got %0d/%h want 0/0", chosen, out_bits); end
    n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL reset_lock_err: got %b want 0", lock_err); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    settle();
    n_checks++; if (chosen !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_first_grant: got %0d v=%b want 0 v=1", chosen, out_valid); end
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b want 0001", in_ready); end
    adv();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want_rdy;
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      want_rdy = N'(1) << (c % N);
      n_checks++; if (chosen !== IDX_W'(c % N)) begin n_fail++; $display("FAIL rr_chosen c%0d: got %0d want %0d", c, chosen, c % N); end
      n_checks++; if (in_ready !== want_rdy) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, in_ready, want_rdy); end
      n_checks++; if (out_bits !== bits_a[c % N]) begin n_fail++; $display("FAIL rr_bits c%0d: got %h want %h", c, out_bits, bits_a[c % N]); end
      adv();
    end
  endtask

  task automatic test_burst();
    int exp_ch [6] = '{1, 1, 1, 1, 2, 0};
    bit exp_lk [6] = '{0, 1, 1, 1, 0, 0};
    do_reset();
    prime();
    in_valid   = 4'b0111;
    beats_a[1] = 4'd3;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_checks++; if (chosen !== IDX_W'(exp_ch[c]) || out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_chosen c%0d: got %0d v=%b want %0d v=1", c, chosen, out_valid, exp_ch[c]); end
      n_checks++; if (locked !== exp_lk[c]) begin n_fail++; $display("FAIL burst_locked c%0d: got %b want %b", c, locked, exp_lk[c]); end
      n_checks++; if (in_ready !== (N'(1) << exp_ch[c])) begin n_fail++; $display("FAIL burst_ready c%0d: got %b want one-hot %0d", c, in_ready, exp_ch[c]); end
      adv();
      if (c == 3) in_valid[1] = 1'b0;
      if (c == 4) in_valid[2] = 1'b0;
      if (c == 5) in_valid[0] = 1'b0;
    end
  endtask

  task automatic test_stall();
    bit orun  [10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int fires1;
    fires1 = 0;
    do_reset();
    prime();
    in_valid   = 4'b0111;
    beats_a[1] = 4'd3;
    for (int c = 0; c < 10; c++) begin
      out_ready = orun[c];
      settle();
      if (in_valid[1] && in_ready[1]) fires1++;
      n_checks++; if (chosen !== ((c == 9) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL stall_chosen c%0d: got %0d want %0d", c, chosen, (c == 9) ? 2 : 1); end
      n_checks++; if (locked !== (c >= 1 && c <= 8)) begin n_fail++; $display("FAIL stall_locked c%0d: got %b want %b", c, locked, (c >= 1 && c <= 8)); end
      if (!orun[c]) begin
        n_checks++; if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold c%0d: got rdy=%b v=%b want 0000 v=1", c, in_ready, out_valid); end
      end
      adv();
      if (c == 8) in_valid[1] = 1'b0;
    end
    n_checks++; if (fires1 !== 4) begin n_fail++; $display("FAIL stall_fire_count: got %0d want 4", fires1); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    prime();
    in_valid   = 4'b1111;
    beats_a[1] = 4'd3;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_checks++; if (chosen !== 2'd1) begin n_fail++; $display("FAIL rmid_beat c%0d: got %0d want 1", c, chosen); end
      adv();
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_locked: got %b want 1", locked); end
    reset_n = 1'b0;
    model_reset();
    settle();
    n_checks++; if (locked !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_abort: got lk=%b v=%b rdy=%b want 0 0 0000", locked, out_valid, in_ready); end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    settle();
    n_checks++; if (chosen !== 2'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got ch=%0d lk=%b want 0 0", chosen, locked); end
    adv();
  endtask

  task automatic test_random();
    bit f;
    int g, r;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      settle();
      n_checks++;
      if (out_valid !== e_ov || chosen !== e_chosen || in_ready !== e_ready || out_bits !== e_bits ||
          locked !== e_locked || lock_err !== e_err) begin
        n_fail++;
        $display("FAIL rand c%0d: got v=%b ch=%0d rdy=%b bits=%h lk=%b err=%b want v=%b ch=%0d rdy=%b bits=%h lk=%b err=%b",
                 cyc, out_valid, chosen, in_ready, out_bits, locked, lock_err,
                 e_ov, e_chosen, e_ready, e_bits, e_locked, e_err);
      end
      f = e_fire;
      g = e_g;
      adv();
      for (int i = 0; i < N; i++) begin
        if ((f && g == i) || !in_valid[i]) begin
          if (in_valid[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0)) begin
            in_valid[i] = 1'b1;
            bits_a[i]   = W'($urandom);
            r           = int'($urandom_range(0, 9));
            beats_a[i]  = BEAT_W'((r < 5) ? 0 : (r < 9) ? (r - 4) : 15);
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    prime();
    in_valid   = 4'b0010;
    beats_a[1] = 4'd3;
    settle();
    adv();
    in_valid[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      n_checks++; if (locked !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wdog_hold k%0d: got lk=%b v=%b want 1 0", k, locked, out_valid); end
      n_checks++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL wdog_early k%0d: got %b want 0", k, lock_err); end
      adv();
    end
    in_valid[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++; if (lock_err !== EXP_ERR || lock_err !== e_err) begin n_fail++; $display("FAIL wdog_err c%0d: got %b want %b", c, lock_err, EXP_ERR); end
      n_checks++; if (locked !== 1'b1 || chosen !== 2'd1) begin n_fail++; $display("FAIL wdog_resume c%0d: got lk=%b ch=%0d want 1 1", c, locked, chosen); end
      adv();
    end
    in_valid = '0;
    settle();
    n_checks++; if (locked !== 1'b0 || lock_err !== EXP_ERR) begin n_fail++; $display("FAIL wdog_sticky: got lk=%b err=%b want 0 %b", locked, lock_err, EXP_ERR); end
    adv();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_reset_mid_burst();
    test_random();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
